// File: rtl/vo_pkg.sv
// Shared definitions for the keypoint collection path: field widths,
// the packed keypoint record and the collector FSM state encoding.
package vo_pkg;

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned ORIENT_W = 10;
    localparam int unsigned SCORE_W  = 8;
    localparam int unsigned COUNT_W  = 10;

    typedef struct packed {
        logic [COORD_W-1:0]  x;
        logic [COORD_W-1:0]  y;
        logic [ORIENT_W-1:0] orient;
        logic [SCORE_W-1:0]  score;
    } keypoint_t;

    localparam int unsigned KP_W = $bits(keypoint_t);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

endpackage

// File: rtl/feature_fifo.sv
// Synchronous keypoint FIFO with a registered head-of-queue output.
// Pointers wrap modulo DEPTH (power of two); a separate occupancy counter
// runs 0..DEPTH. A push into an empty FIFO is visible on rd_data one
// cycle later; there is no combinational bypass.
module feature_fifo
    import vo_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [KP_W-1:0]          wr_data,
    input  logic                     pop,
    output logic [KP_W-1:0]          rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [KP_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_next;
    logic [AW:0]     count_q;
    logic [KP_W-1:0] head_q;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign count   = count_q;
    assign rd_data = head_q;
    assign rd_next = rd_ptr + AW'(1);

    // A pop frees a slot, so a full FIFO can still take a push in that cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage array; contents need no reset because occupancy gates reads
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered head entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            // Head is the incoming word when the queue is (or becomes) otherwise
            // empty; else the entry behind the one being popped.
            if (do_push && (empty || (count_q == (AW+1)'(1) && do_pop))) begin
                head_q <= wr_data;
            end else if (do_pop && count_q > (AW+1)'(1)) begin
                head_q <= mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/feature_collector.sv
// Keypoint collector: captures flagged detector beats of a frame into a
// FIFO and presents them on a valid/ready handshake, with per-frame count,
// sticky overflow flag and a frame-done pulse once the frame has drained.
// Optional build macro FEATURE_COLLECTOR_SCORE_FILTER_EN: when defined,
// beats scoring below SCORE_TH are not eligible for capture.
module feature_collector
    import vo_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter logic [7:0]  SCORE_TH = 8'd20
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [COORD_W-1:0]  i_coordinate_X,
    input  logic [COORD_W-1:0]  i_coordinate_Y,
    input  logic [ORIENT_W-1:0] i_orientation,
    input  logic [SCORE_W-1:0]  i_score,
    input  logic                i_flag,
    input  logic                i_start,
    input  logic                i_end,
    input  logic                i_ready,
    output logic                o_valid,
    output logic [COORD_W-1:0]  o_kp_x,
    output logic [COORD_W-1:0]  o_kp_y,
    output logic [ORIENT_W-1:0] o_kp_orient,
    output logic [SCORE_W-1:0]  o_kp_score,
    output logic [COUNT_W-1:0]  o_kp_count,
    output logic                o_frame_done,
    output logic                o_overflow,
    output logic                o_busy
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_t               state;
    state_t               state_nxt;
    logic                 frame_done_nxt;
    logic [COUNT_W-1:0]   kp_count_q;
    logic [COUNT_W-1:0]   count_base;
    logic [COUNT_W-1:0]   kp_count_nxt;
    logic                 overflow_q;
    logic                 overflow_nxt;
    logic                 frame_done_q;

    logic                 eligible;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [AW:0]          fifo_level;
    keypoint_t            wr_kp;
    keypoint_t            head_kp;
    logic [KP_W-1:0]      head_bits;

`ifdef FEATURE_COLLECTOR_SCORE_FILTER_EN
    assign eligible = i_flag && (state == COLLECT || i_start) && (i_score >= SCORE_TH);
`else
    logic score_th_unused;
    assign score_th_unused = ^SCORE_TH;
    assign eligible = i_flag && (state == COLLECT || i_start);
`endif

    assign pop  = o_valid && i_ready;
    assign push = eligible && (!fifo_full || pop);
    assign drop = eligible && !push;

    assign wr_kp = '{x: i_coordinate_X, y: i_coordinate_Y,
                     orient: i_orientation, score: i_score};

    feature_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .push    (push),
        .wr_data (wr_kp),
        .pop     (pop),
        .rd_data (head_bits),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_level)
    );

    assign head_kp      = keypoint_t'(head_bits);
    assign o_valid      = !fifo_empty;
    assign o_kp_x       = head_kp.x;
    assign o_kp_y       = head_kp.y;
    assign o_kp_orient  = head_kp.orient;
    assign o_kp_score   = head_kp.score;
    assign o_kp_count   = kp_count_q;
    assign o_overflow   = overflow_q;
    assign o_frame_done = frame_done_q;
    assign o_busy       = (state != IDLE);

    // Next-state: i_start restarts from any state and suppresses frame-done
    always_comb begin
        state_nxt      = state;
        frame_done_nxt = 1'b0;
        if (i_start) begin
            state_nxt = i_end ? DRAIN : COLLECT;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                COLLECT: if (i_end) state_nxt = DRAIN;
                DRAIN: begin
                    if (fifo_level == '0) begin
                        state_nxt      = IDLE;
                        frame_done_nxt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Frame statistics: start clears, then this beat's push/drop applies
    always_comb begin
        count_base   = i_start ? '0 : kp_count_q;
        kp_count_nxt = count_base;
        if (push && count_base != '1) begin
            kp_count_nxt = count_base + 10'd1;
        end
        overflow_nxt = (i_start ? 1'b0 : overflow_q) | drop;
    end

    // State and frame status registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            kp_count_q   <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            kp_count_q   <= kp_count_nxt;
            overflow_q   <= overflow_nxt;
            frame_done_q <= frame_done_nxt;
        end
    end

endmodule
